apb_mem_target: RTL and testbench

Byte-wide register-array memory sitting directly downstream of each APB slave on its Memory_Bus. Accepts one read or write request at a time from the slave, models a configurable access latency, and returns completion on a single-cycle `ready` pulse with `error` status. Serves as the storage target behind `APB_Slave` in system simulation and FPGA builds.

---
 rtl/apb_mem_target.sv | 154 +++++++++++++++
 tb/tb_apb_mem_target.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/apb_mem_target.sv
// apb_mem_target: byte-wide register-array memory behind an APB slave, with a
// configurable access latency. Define MEM_WPROT_EN to write-protect addr >= WP_BASE.
module apb_mem_target #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2,
    parameter logic [7:0]  WP_BASE = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       wren,
    input  logic       rden,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       ready,
    output logic       error
);
    localparam int unsigned IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  LAT     = 4'(LATENCY);
    localparam logic [8:0]  DEPTH_W = 9'(DEPTH);
`ifdef MEM_WPROT_EN
    localparam logic        WPROT_EN = 1'b1;
`else
    localparam logic        WPROT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic       wr_q;
    logic       err_q;
    logic [7:0] rdata_q;
    logic       ready_q;
    logic       error_q;
    logic [7:0] mem_q [DEPTH];

    logic          req_s;
    logic          req_err_s;
    logic          wp_hit_s;
    logic          commit_s;
    logic          acc_wr_s;
    logic          acc_err_s;
    logic [7:0]    acc_addr_s;
    logic [7:0]    acc_wdata_s;
    logic [IW-1:0] idx_s;

    assign wp_hit_s = WPROT_EN && wren && (addr >= WP_BASE);

    // Request decode, plus the access that commits on the edge entering DONE
    // (taken straight from the inputs when a zero-latency request is accepted).
    always_comb begin
        req_s     = ce && (wren || rden);
        req_err_s = (wren && rden) || ({1'b0, addr} >= DEPTH_W) || wp_hit_s;
        if (state_q == IDLE) begin
            acc_addr_s  = addr;
            acc_wdata_s = wdata;
            acc_wr_s    = wren;
            acc_err_s   = req_err_s;
            commit_s    = req_s && (LAT == 4'd0);
        end else begin
            acc_addr_s  = addr_q;
            acc_wdata_s = wdata_q;
            acc_wr_s    = wr_q;
            acc_err_s   = err_q;
            commit_s    = (state_q == BUSY) && ce && (cnt_q == 4'd1);
        end
        idx_s = acc_addr_s[IW-1:0];
    end

    // Control FSM, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 8'h00;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ready_q <= (state_q == DONE);
            error_q <= (state_q == DONE) && err_q;
            // Errored accesses of either kind zero rdata; clean writes leave it alone.
            if (commit_s && (acc_err_s || !acc_wr_s)) begin
                rdata_q <= acc_err_s ? 8'h00 : mem_q[idx_s];
            end else begin
                rdata_q <= rdata_q;
            end
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wr_q    <= wren;
                        err_q   <= req_err_s;
                        if (LAT == 4'd0) begin
                            state_q <= DONE;
                            cnt_q   <= 4'd0;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= LAT;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                BUSY: begin
                    if (!ce) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd1) begin
                        state_q <= DONE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q   <= cnt_q - 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    // Storage array; only clean writes that reach completion modify it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (commit_s && acc_wr_s && !acc_err_s) begin
            mem_q[idx_s] <= acc_wdata_s;
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign error = error_q;

endmodule

// File: tb/tb_apb_mem_target.sv
// Randomised bench for apb_mem_target: three instances (latency 2, latency 0,
// depth 128 / latency 3) share one stimulus stream and are scored against a transaction model.
module tb_apb_mem_target;
    localparam int N = 3;
    localparam int W = 6;
`ifdef MEM_WPROT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    int lat [N] = '{2, 0, 3};
    int dep [N] = '{256, 256, 128};

    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic       wren;
    logic       rden;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata_w [N];
    logic       ready_w [N];
    logic       error_w [N];

    logic [7:0] mdl_mem [N][256];
    logic [7:0] mdl_rd  [N];
    logic [7:0] hot     [8];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    apb_mem_target #(.DEPTH(256), .LATENCY(2), .WP_BASE(8'hF0)) u_dut_l2 (
        .clk(clk), .reset(reset), .ce(ce), .wren(wren), .rden(rden), .addr(addr),
        .wdata(wdata), .rdata(rdata_w[0]), .ready(ready_w[0]), .error(error_w[0]));

    apb_mem_target #(.DEPTH(256), .LATENCY(0), .WP_BASE(8'hF0)) u_dut_l0 (
        .clk(clk), .reset(reset), .ce(ce), .wren(wren), .rden(rden), .addr(addr),
        .wdata(wdata), .rdata(rdata_w[1]), .ready(ready_w[1]), .error(error_w[1]));

    apb_mem_target #(.DEPTH(128), .LATENCY(3), .WP_BASE(8'hF0)) u_dut_d128 (
        .clk(clk), .reset(reset), .ce(ce), .wren(wren), .rden(rden), .addr(addr),
        .wdata(wdata), .rdata(rdata_w[2]), .ready(ready_w[2]), .error(error_w[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < N; i++) begin
            mdl_rd[i] = 8'h00;
            for (int j = 0; j < 256; j++) mdl_mem[i][j] = 8'h00;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s ready[%0d]", tag, i), 32'(ready_w[i]), 32'd0);
            chk($sformatf("%s error[%0d]", tag, i), 32'(error_w[i]), 32'd0);
            chk($sformatf("%s rdata[%0d]", tag, i), 32'(rdata_w[i]), 32'd0);
        end
    endtask

    // One transaction; ce stays high for h cycles after acceptance, then drops.
    task automatic do_txn(input logic wr, input logic rd, input logic [7:0] a,
                          input logic [7:0] d, input int h);
        bit comp [N];
        bit err  [N];
        bit exp_rdy;
        ce = 1'b1; wren = wr; rden = rd; addr = a; wdata = d;
        for (int i = 0; i < N; i++) begin
            comp[i] = (h >= lat[i]);
            err[i]  = (wr && rd) || (int'(a) >= dep[i]) || (WPROT && wr && (a >= 8'hF0));
            if (comp[i]) begin
                if (err[i])  mdl_rd[i] = 8'h00;
                else if (wr) mdl_mem[i][a] = d;
                else         mdl_rd[i] = mdl_mem[i][a];
            end
        end
        tick();
        for (int c = 1; c <= W; c++) begin
            ce = (c <= h);
            if (c == 1) begin
                wren = 1'($urandom); rden = 1'($urandom);
                addr = 8'($urandom); wdata = 8'($urandom);
            end else begin
                wren = 1'b0; rden = 1'b0;
            end
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                exp_rdy = comp[i] && (c == lat[i] + 2);
                chk($sformatf("ready[%0d] a=%0h c%0d", i, a, c), 32'(ready_w[i]), 32'(exp_rdy));
                chk($sformatf("error[%0d] a=%0h c%0d", i, a, c), 32'(error_w[i]),
                    32'(exp_rdy && err[i]));
                if (exp_rdy || c == W)
                    chk($sformatf("rdata[%0d] a=%0h c%0d", i, a, c), 32'(rdata_w[i]),
                        32'(mdl_rd[i]));
            end
            tick();
        end
    endtask

    initial begin
        logic       r_wr;
        logic       r_rd;
        logic [7:0] r_a;
        int         r_op;
        int         r_h;
        hot[0] = 8'h10; hot[1] = 8'h40; hot[2] = 8'h05; hot[3] = 8'hF4;
        hot[4] = 8'h80; hot[5] = 8'h7F; hot[6] = 8'hFF; hot[7] = 8'h00;

        reset = 1'b1; ce = 1'b0; wren = 1'b0; rden = 1'b0; addr = 8'h00; wdata = 8'h00;
        repeat (3) tick();
        @(negedge clk);
        chk_idle_outputs("reset");
        tick();
        reset = 1'b0;
        mdl_clear();

        do_txn(1'b0, 1'b1, 8'h20, 8'h00, W);
        do_txn(1'b1, 1'b0, 8'h10, 8'hA5, W);
        do_txn(1'b0, 1'b1, 8'h10, 8'h00, W);
        do_txn(1'b1, 1'b0, 8'h05, 8'h5A, W);
        do_txn(1'b1, 1'b1, 8'h05, 8'hFF, W);
        do_txn(1'b0, 1'b1, 8'h05, 8'h00, W);
        do_txn(1'b1, 1'b0, 8'h00, 8'h11, W);
        do_txn(1'b1, 1'b0, 8'h80, 8'h22, W);
        do_txn(1'b0, 1'b1, 8'h00, 8'h00, W);
        do_txn(1'b0, 1'b1, 8'h80, 8'h00, W);
        do_txn(1'b1, 1'b0, 8'h40, 8'hC3, W);
        do_txn(1'b1, 1'b0, 8'h40, 8'h3C, 1);
        do_txn(1'b0, 1'b1, 8'h40, 8'h00, W);
        do_txn(1'b1, 1'b0, 8'hF4, 8'h77, W);
        do_txn(1'b0, 1'b1, 8'hF4, 8'h00, W);

        for (int t = 0; t < 200; t++) begin
            r_op = int'($urandom_range(0, 9));
            r_wr = (r_op <= 4);
            r_rd = (r_op == 0) || (r_op >= 5);
            r_a  = ($urandom_range(0, 1) == 0) ? hot[$urandom_range(0, 7)] : 8'($urandom);
            r_h  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : W;
            do_txn(r_wr, r_rd, r_a, 8'($urandom), r_h);
        end

        // Reset while a write is in flight: outputs clear and the array is wiped.
        ce = 1'b1; wren = 1'b1; rden = 1'b0; addr = 8'h33; wdata = 8'h99;
        tick();
        wren = 1'b0;
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk_idle_outputs("midop reset");
        tick();
        reset = 1'b0; ce = 1'b0;
        mdl_clear();
        do_txn(1'b0, 1'b1, 8'h33, 8'h00, W);
        do_txn(1'b0, 1'b1, 8'h10, 8'h00, W);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
